seq_detector_param: RTL



---
 rtl/seq_detector_param.sv | 100 ++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Serial pattern detector with a run-time loadable pattern, Mealy
//             and registered match flags, and a saturating match counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
    parameter int                   PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] DEFAULT_PAT = 'b1011,
    parameter int                   CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_in,
    input  logic                 x_valid,
    input  logic                 overlap,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
    input  logic                 cnt_clr,
    output logic                 y_out,
    output logic                 y_q,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 cnt_sat
);

    localparam int                FILL_W   = (PATTERN_W > 2) ? $clog2(PATTERN_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t                 r_state;
    logic [PATTERN_W-1:0]   r_pattern;
    logic [PATTERN_W-2:0]   r_hist;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_y_q;
    logic [CNT_W-1:0]       r_cnt;

    logic [PATTERN_W-1:0]   w_cand;
    logic                   w_match;
    logic                   w_sat;

    assign w_cand  = {r_hist, x_in};
    // ARMED guarantees a full window, so a zero pattern cannot hit on reset-cleared history.
    assign w_match = !rst && (r_state == ST_ARMED) && x_valid && !pat_load
                     && (w_cand == r_pattern);
    assign w_sat   = &r_cnt;

    assign y_out     = w_match;
    assign y_q       = r_y_q;
    assign match_cnt = r_cnt;
    assign cnt_sat   = w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= DEFAULT_PAT;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= ST_FILL;
            r_y_q     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_y_q <= w_match;

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_match && !w_sat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (pat_load) begin
                r_pattern <= pat_in;
                r_hist    <= '0;
                r_fill    <= '0;
                r_state   <= ST_FILL;
            end else if (x_valid) begin
                if (w_match && !overlap) begin
                    r_hist  <= '0;
                    r_fill  <= '0;
                    r_state <= ST_FILL;
                end else begin
                    r_hist <= w_cand[PATTERN_W-2:0];
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                    if (r_fill >= FILL_MAX - FILL_W'(1)) begin
                        r_state <= ST_ARMED;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
